// File: rtl/bram_log_ctrl.sv
// Debug-log BRAM controller: captures a sample stream into a single-port BRAM,
// then serves host word reads through the same port when no capture is running.
module bram_log_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              i_reset,
    input  logic              i_run,
    input  logic              i_stop,
    input  logic              i_sample_vld,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic [DATA_W-1:0] i_bram_data,
    output logic              o_bram_en,
    output logic              o_bram_we,
    output logic [ADDR_W-1:0] o_bram_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_vld,
    output logic              o_full,
    output logic              o_busy,
    output logic [ADDR_W:0]   o_wr_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_CAPTURE = 2'b01,
        S_RD_ADDR = 2'b10,
        S_RD_DATA = 2'b11
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]     wr_count_q, wr_count_d;
    logic                full_q, full_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_vld_q, rd_vld_d;

    always_ff @(posedge clock) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            wr_count_q <= '0;
            full_q     <= 1'b0;
            rd_addr_q  <= '0;
            rd_data_q  <= '0;
            rd_vld_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            wr_count_q <= wr_count_d;
            full_q     <= full_d;
            rd_addr_q  <= rd_addr_d;
            rd_data_q  <= rd_data_d;
            rd_vld_q   <= rd_vld_d;
        end
    end

    // BRAM strobes are masked by reset so a reset cycle never touches memory.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        wr_count_d  = wr_count_q;
        full_d      = full_q;
        rd_addr_d   = rd_addr_q;
        rd_data_d   = rd_data_q;
        rd_vld_d    = 1'b0;
        o_bram_en   = 1'b0;
        o_bram_we   = 1'b0;
        o_bram_addr = '0;

        case (state_q)
            S_IDLE: begin
                if (i_run) begin
                    state_d    = S_CAPTURE;
                    wr_ptr_d   = '0;
                    wr_count_d = '0;
                    full_d     = 1'b0;
                end else if (i_rd_req) begin
                    rd_addr_d = i_rd_addr;
                    state_d   = S_RD_ADDR;
                end
            end
            S_CAPTURE: begin
                o_bram_addr = wr_ptr_q;
                o_bram_en   = i_sample_vld & ~i_reset;
                o_bram_we   = i_sample_vld & ~i_reset;
                if (i_sample_vld) begin
                    wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
                    wr_count_d = wr_count_q + (ADDR_W + 1)'(1);
                    if (wr_ptr_q == LAST_ADDR) begin
                        full_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                if (i_stop) begin
                    state_d = S_IDLE;
                end
            end
            S_RD_ADDR: begin
                o_bram_en   = ~i_reset;
                o_bram_addr = rd_addr_q;
                state_d     = S_RD_DATA;
            end
            S_RD_DATA: begin
                o_bram_addr = rd_addr_q;
                rd_data_d   = i_bram_data;
                rd_vld_d    = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_rd_data  = rd_data_q;
    assign o_rd_vld   = rd_vld_q;
    assign o_full     = full_q;
    assign o_busy     = (state_q != S_IDLE);
    assign o_wr_count = wr_count_q;

endmodule

// File: tb/tb_bram_log_ctrl.sv
// Randomized scoreboard bench for bram_log_ctrl with a 16-word BRAM model and
// a transaction-level reference model of capture and readback.
module tb_bram_log_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 16;

    logic          clock;
    logic          i_reset, i_run, i_stop, i_sample_vld, i_rd_req;
    logic [AW-1:0] i_rd_addr;
    logic [DW-1:0] i_bram_data;
    logic          o_bram_en, o_bram_we;
    logic [AW-1:0] o_bram_addr;
    logic [DW-1:0] o_rd_data;
    logic          o_rd_vld, o_full, o_busy;
    logic [AW:0]   o_wr_count;
    logic [DW-1:0] sdata;

    bram_log_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clock), .i_reset(i_reset), .i_run(i_run), .i_stop(i_stop),
        .i_sample_vld(i_sample_vld), .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr),
        .i_bram_data(i_bram_data), .o_bram_en(o_bram_en), .o_bram_we(o_bram_we),
        .o_bram_addr(o_bram_addr), .o_rd_data(o_rd_data), .o_rd_vld(o_rd_vld),
        .o_full(o_full), .o_busy(o_busy), .o_wr_count(o_wr_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // BRAM with 1-cycle registered read; write data comes from the sample bus
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clock) begin
        if (o_bram_en) begin
            if (o_bram_we) mem[o_bram_addr] <= sdata;
            i_bram_data <= mem[o_bram_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // reference model state
    logic [DW-1:0] ref_mem [DEPTH];
    logic [AW-1:0] exp_wr [$];
    logic [DW-1:0] exp_rd [$];
    bit            m_cap, m_full, m_vld;
    int            m_cnt, m_rd;
    logic [AW-1:0] m_lat;

    task automatic check_state();
        chk("busy", int'(o_busy), int'(m_cap || m_rd > 0));
        chk("wr_count", int'(o_wr_count), m_cnt);
        chk("full", int'(o_full), int'(m_full));
        chk("rd_vld", int'(o_rd_vld), int'(m_vld));
        if (!m_cap && m_rd == 0) begin
            chk("idle_en", int'(o_bram_en), 0);
            chk("idle_addr", int'(o_bram_addr), 0);
        end
        if (m_rd == 2) begin
            chk("rd_en", int'(o_bram_en), 1);
            chk("rd_we", int'(o_bram_we), 0);
            chk("rd_addr", int'(o_bram_addr), int'(m_lat));
        end
    endtask

    task automatic step(input bit r_run, input bit r_stop, input bit r_vld,
                        input logic [DW-1:0] r_data, input bit r_rd,
                        input logic [AW-1:0] r_addr, input bit r_rst);
        @(negedge clock);
        check_state();
        i_run = r_run; i_stop = r_stop; i_sample_vld = r_vld; sdata = r_data;
        i_rd_req = r_rd; i_rd_addr = r_addr; i_reset = r_rst;
        if (r_rst) begin
            if (m_rd > 0) void'(exp_rd.pop_back());
            m_cap = 0; m_cnt = 0; m_full = 0; m_rd = 0; m_vld = 0;
        end else begin
            m_vld = (m_rd == 1);
            if (m_cap) begin
                if (r_vld) begin
                    exp_wr.push_back(AW'(m_cnt));
                    ref_mem[m_cnt] = r_data;
                    m_cnt++;
                    if (m_cnt == DEPTH) begin
                        m_cap = 0;
                        m_full = 1;
                    end
                end
                if (r_stop) m_cap = 0;
            end else if (m_rd > 0) begin
                m_rd--;
            end else if (r_run) begin
                m_cap = 1; m_cnt = 0; m_full = 0;
            end else if (r_rd) begin
                exp_rd.push_back(ref_mem[r_addr]);
                m_rd = 2;
                m_lat = r_addr;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 16'($urandom), 0, 4'($urandom), 0);
    endtask

    // monitor: pops expectations whenever the DUT writes or presents read data
    always @(negedge clock) begin
        #3;
        if (o_bram_en === 1'b1 && o_bram_we === 1'b1) begin
            if (exp_wr.size() == 0) begin
                checks++; errors++;
                $display("FAIL wr_unexpected: write at addr %0d, none expected", o_bram_addr);
            end else begin
                chk("wr_addr", int'(o_bram_addr), int'(exp_wr.pop_front()));
            end
        end
        if (o_rd_vld === 1'b1) begin
            if (exp_rd.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_unexpected: data %0h, no read pending", o_rd_data);
            end else begin
                chk("rd_data", int'(o_rd_data), int'(exp_rd.pop_front()));
            end
        end
    end

    initial begin
        for (int k = 0; k < DEPTH; k++) begin
            mem[k] = '0;
            ref_mem[k] = '0;
        end
        i_reset = 1; i_run = 0; i_stop = 0; i_sample_vld = 0; i_rd_req = 0;
        i_rd_addr = '0; sdata = '0;
        // reset with all other inputs toggling
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            i_run = 1'($urandom); i_stop = 1'($urandom); i_sample_vld = 1'($urandom);
            i_rd_req = 1'($urandom); i_rd_addr = 4'($urandom); sdata = 16'($urandom);
        end
        m_cap = 0; m_full = 0; m_vld = 0; m_cnt = 0; m_rd = 0; m_lat = '0;
        step(0, 0, 0, 0, 0, 0, 0);
        chk("reset_rd_data", int'(o_rd_data), 0);

        // full capture, data 0..15 on every cycle
        step(1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < DEPTH; k++) step(0, 0, 1, 16'(k), 0, 0, 0);
        idle(2);

        // read addr 5, with a second request one cycle later that must be dropped
        step(0, 0, 0, 0, 1, 4'd5, 0);
        step(0, 0, 0, 0, 1, 4'd9, 0);
        idle(3);
        // read back every word in random order
        for (int k = 0; k < DEPTH; k++) begin
            step(0, 0, 0, 0, 1, 4'($urandom), 0);
            idle(2);
        end

        // sparse strobes every third cycle, then stop
        step(1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 24; k++) step(0, 0, (k % 3) == 2, 16'($urandom), 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        idle(2);

        // stop after six samples; restart with a simultaneous read request
        step(1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) step(0, 0, 1, 16'($urandom), 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        idle(2);
        step(1, 0, 0, 0, 1, 4'd3, 0);
        step(0, 0, 1, 16'hbeef, 1, 4'd2, 0);
        step(0, 1, 1, 16'hcafe, 0, 0, 0);
        idle(4);

        // reset on the seventh sample, then a fresh capture must start at addr 0
        step(1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) step(0, 0, 1, 16'($urandom), 0, 0, 0);
        step(0, 0, 1, 16'($urandom), 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 16'h1234, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        idle(2);
        step(0, 0, 0, 0, 1, 4'd0, 0);
        idle(3);

        // random traffic
        for (int k = 0; k < 600; k++) begin
            step($urandom_range(99) < 6, $urandom_range(99) < 3, 1'($urandom),
                 16'($urandom), $urandom_range(99) < 25, 4'($urandom),
                 $urandom_range(199) == 0);
        end
        idle(4);
        @(negedge clock);
        chk("wr_queue_drained", exp_wr.size(), 0);
        chk("rd_queue_drained", exp_rd.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
